// File: rtl/instruction_set_pkg.sv
// Shared display types: data word width, active-low 7-segment glyphs, display modes.
package instruction_set;

  localparam int WORD_SIZE = 8;

  typedef enum logic [1:0] {
    MODE_HEX    = 2'd0,
    MODE_RAW    = 2'd1,
    MODE_SCROLL = 2'd2
  } display_mode_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order gfedcba, a driven-low segment is lit.
  localparam logic [6:0] HEX_DIGITS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/display_manager_tick_divider.sv
// Prescaler: tick is high for one cycle out of every DIV; clr restarts the count.
// Tick is combinational from the count register, so it lines up with the edge that consumes it.
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1)) && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/display_manager.sv
// Double-buffered seven-segment driver with hex/raw/scroll modes and per-digit blink.
// Commit loads the front buffer on one edge; hex_out reflects it on the next.
module display_manager
  import instruction_set::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 12_500_000,
  parameter int SCROLL_DIV = 25_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0]          wr_data,
  input  logic                          commit,
  input  logic [1:0]                    mode,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  output logic [NUM_DIGITS*7-1:0]       hex_out,
  output logic                          commit_ack
);

  localparam int AW = $clog2(NUM_DIGITS);

  logic [WORD_SIZE-1:0]    shadow     [NUM_DIGITS];
  logic [WORD_SIZE-1:0]    shadow_nxt [NUM_DIGITS];
  logic [WORD_SIZE-1:0]    front      [NUM_DIGITS];
  logic                    front_valid;
  logic                    blink_phase;
  logic                    blink_tick;
  logic                    scroll_tick;
  logic                    scroll_clr;
  logic                    wr_hit;
  logic [AW-1:0]           offset;
  logic [NUM_DIGITS*7-1:0] hex_nxt;

  assign wr_hit     = wr_en && ({1'b0, wr_addr} < (AW+1)'(NUM_DIGITS));
  assign scroll_clr = (mode != MODE_SCROLL);

  // The front buffer copies shadow_nxt so a same-cycle write reaches it.
  always_comb begin
    shadow_nxt = shadow;
    if (wr_hit)
      shadow_nxt[wr_addr] = wr_data;
  end

  tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .tick  (blink_tick)
  );

  tick_divider #(.DIV(SCROLL_DIV)) u_scroll_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scroll_clr),
    .tick  (scroll_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        front[i]  <= '0;
      end
      front_valid <= 1'b0;
      commit_ack  <= 1'b0;
      blink_phase <= 1'b0;
      offset      <= '0;
      hex_out     <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      shadow <= shadow_nxt;
      if (commit) begin
        front       <= shadow_nxt;
        front_valid <= 1'b1;
      end
      commit_ack <= commit;
      if (blink_tick)
        blink_phase <= ~blink_phase;
      if (scroll_clr)
        offset <= '0;
      else if (scroll_tick)
        offset <= (offset == AW'(NUM_DIGITS - 1)) ? '0 : offset + 1'b1;
      hex_out <= hex_nxt;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [AW:0]   sum;
    logic [AW-1:0] sidx;
    logic [6:0]    seg;
    logic          unused_msb;

    assign unused_msb = front[i][WORD_SIZE-1];
    assign sum  = (AW+1)'(i) + {1'b0, offset};
    assign sidx = (sum >= (AW+1)'(NUM_DIGITS)) ? AW'(sum - (AW+1)'(NUM_DIGITS)) : sum[AW-1:0];

    always_comb begin
      case (mode)
        MODE_RAW:    seg = front[i][6:0];
        MODE_SCROLL: seg = HEX_DIGITS[front[sidx][3:0]];
        default:     seg = HEX_DIGITS[front[i][3:0]];
      endcase
      if (!front_valid || (blink_phase && blink_mask[i]))
        seg = SEG_BLANK;
    end

    assign hex_nxt[i*7 +: 7] = seg;
  end

endmodule

// File: tb/tb_display_manager.sv
// Directed bench for display_manager with NUM_DIGITS=6, BLINK_DIV=4, SCROLL_DIV=3.
module tb_display_manager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        commit;
  logic [1:0]  mode;
  logic [5:0]  blink_mask;
  logic [41:0] hex_out;
  logic        commit_ack;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  display_manager #(
    .NUM_DIGITS (6),
    .BLINK_DIV  (4),
    .SCROLL_DIV (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .mode       (mode),
    .blink_mask (blink_mask),
    .hex_out    (hex_out),
    .commit_ack (commit_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step(1);
    wr_en   = 1'b0;
  endtask

  // Entries hold 0..5; digit i shows entry (i+off) mod 6.
  function automatic logic [41:0] hex_vec(input int off);
    logic [41:0] v;
    for (int i = 0; i < 6; i++)
      v[i*7 +: 7] = SEG[(i + off) % 6];
    return v;
  endfunction

  initial begin
    logic [41:0] exp_v;
    logic [6:0]  cur;
    logic [6:0]  prev;
    logic        found;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; mode = 2'd0; blink_mask = '0;
    #12;
    check("rst_hex", hex_out, ALL_BLANK);
    check("rst_ack", commit_ack, 1'b0);
    step(1);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      check("idle_hex", hex_out, ALL_BLANK);
      check("idle_ack", commit_ack, 1'b0);
    end

    for (int i = 0; i < 6; i++) wr(3'(i), 8'(i));
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    check("commit_ack", commit_ack, 1'b1);
    check("commit_hex_early", hex_out, ALL_BLANK);
    step(1);
    check("commit_ack_drop", commit_ack, 1'b0);
    check("commit_hex", hex_out, hex_vec(0));

    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h0A; commit = 1'b1;
    step(1);
    wr_en = 1'b0; commit = 1'b0;
    check("fwd_ack", commit_ack, 1'b1);
    check("fwd_hex_early", hex_out, hex_vec(0));
    step(1);
    exp_v = hex_vec(0);
    exp_v[14 +: 7] = 7'h08;
    check("fwd_hex", hex_out, exp_v);

    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h02; commit = 1'b1;
    step(1);
    wr_en = 1'b0;
    check("b2b_ack0", commit_ack, 1'b1);
    step(1);
    check("b2b_ack1", commit_ack, 1'b1);
    commit = 1'b0;
    step(1);
    check("b2b_ack2", commit_ack, 1'b0);
    check("b2b_hex", hex_out, hex_vec(0));

    for (int a = 6; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'h0F; commit = 1'b1;
      step(1);
      wr_en = 1'b0; commit = 1'b0;
      step(1);
      check("oob_write", hex_out, hex_vec(0));
    end

    mode = 2'd2;
    step(1);
    check("scroll_d0_k0", hex_out[6:0], SEG[0]);
    for (int k = 1; k <= 6; k++) begin
      step(3);
      check("scroll_d0", hex_out[6:0], SEG[k % 6]);
      if (k == 2) check("scroll_all", hex_out, hex_vec(2));
    end
    step(3);
    check("scroll_off1", hex_out, hex_vec(1));
    mode = 2'd0;
    step(1);
    check("scroll_exit", hex_out, hex_vec(0));

    mode = 2'd1; blink_mask = 6'b000001;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h40; commit = 1'b1;
    step(1);
    wr_en = 1'b0; commit = 1'b0;
    step(1);
    found = 1'b0;
    prev = hex_out[6:0];
    for (int n = 0; n < 10 && !found; n++) begin
      step(1);
      if (hex_out[6:0] != prev) found = 1'b1;
    end
    check("blink_edge", found, 1'b1);
    cur = hex_out[6:0];
    check("blink_val", (cur == 7'h40) || (cur == 7'h7F), 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 3; j++) begin
        step(1);
        check("blink_hold", hex_out[6:0], cur);
        check("blink_others", hex_out[41:7], {7'h05, 7'h04, 7'h03, 7'h02, 7'h01});
      end
      step(1);
      cur = (cur == 7'h40) ? 7'h7F : 7'h40;
      check("blink_flip", hex_out[6:0], cur);
    end

    blink_mask = '0; mode = 2'd2;
    step(10);
    check("pre_rst_off3", hex_out, hex_vec(3));
    rst_n = 1'b0;
    #1;
    check("mid_rst_hex", hex_out, ALL_BLANK);
    check("mid_rst_ack", commit_ack, 1'b0);
    @(posedge clk);
    #1;
    check("rst_held_hex", hex_out, ALL_BLANK);
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h01; commit = 1'b1;
    step(1);
    wr_en = 1'b0; commit = 1'b0;
    check("post_rst_ack", commit_ack, 1'b1);
    check("post_rst_blank", hex_out, ALL_BLANK);
    step(1);
    exp_v = {6{7'h40}};
    exp_v[7 +: 7] = 7'h79;
    check("post_rst_off0", hex_out, exp_v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_manager.md
DISPLAY_MANAGER -- requirements
Module: display_manager

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of seven-segment digits driven (2..16).
REQ-002 SHALL have parameter BLINK_DIV, default 12_500_000, clk cycles per blink phase.
REQ-003 SHALL have parameter SCROLL_DIV, default 25_000_000, clk cycles per scroll step.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  in  1  write one shadow entry this cycle.
REQ-007 SHALL have port wr_addr  in  $clog2(NUM_DIGITS)  shadow entry index.
REQ-008 SHALL have port wr_data  in  WORD_SIZE  shadow entry data.
REQ-009 SHALL have port commit  in  1  copy shadow buffer to front buffer.
REQ-010 SHALL have port mode  in  2  display_mode_t select.
REQ-011 SHALL have port blink_mask  in  NUM_DIGITS  per-digit blink enable.
REQ-012 SHALL have port hex_out  out  NUM_DIGITS x 7  registered segment drive, one 7-bit field per digit.
REQ-013 SHALL have port commit_ack  out  1  one-cycle pulse confirming commit.

Function
REQ-014 Write: wr_en high with wr_addr < NUM_DIGITS SHALL load shadow[wr_addr] on that edge; wr_addr >= NUM_DIGITS SHALL be ignored.
REQ-015 Commit: commit sampled high SHALL load front buffer from shadow on that edge, set front_valid, and assert commit_ack for exactly the following cycle.
REQ-016 Simultaneous wr_en and commit SHALL forward the write: the front buffer receives the newly written entry.
REQ-017 Back-to-back commits SHALL each produce a commit_ack pulse (ack high continuously).
REQ-018 MODE_HEX: digit i SHALL show HEX_DIGITS'(front[i][3:0]).
REQ-019 MODE_RAW: digit i SHALL show front[i][6:0] unencoded.
REQ-020 MODE_SCROLL: digit i SHALL show HEX_DIGITS'(front[(i+offset) mod NUM_DIGITS][3:0]).
REQ-021 mode value 3 SHALL behave as MODE_HEX.
REQ-022 Blink: a prescaler SHALL emit one tick every BLINK_DIV cycles; each tick SHALL toggle blink_phase; while blink_phase=1, digits with blink_mask[i]=1 SHALL show SEG_BLANK.
REQ-023 Scroll: a prescaler SHALL emit one tick every SCROLL_DIV cycles; in MODE_SCROLL each tick SHALL advance offset by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-024 Any cycle with mode != MODE_SCROLL SHALL clear offset and the scroll prescaler to 0.
REQ-025 While front_valid=0, all digits SHALL show SEG_BLANK regardless of mode or mask.
REQ-026 hex_out SHALL be registered: any change of front, mode, blink_mask, blink_phase or offset SHALL appear on hex_out one edge later.
REQ-027 Commit-to-display latency SHALL be 2 edges (front load edge, then hex_out edge).
REQ-028 Blink prescaler SHALL free-run independently of mode, commit and writes.

Reset
REQ-029 rst_n low SHALL immediately clear shadow, front, front_valid, offset, both prescalers, blink_phase and commit_ack to 0, and set every hex_out digit to SEG_BLANK.
REQ-030 Reset asserted mid-commit or mid-scroll SHALL discard the operation; no commit_ack SHALL follow release.
REQ-031 First state change after release SHALL occur on the first rising edge with rst_n high.

Structure
REQ-032 Package instruction_set SHALL hold WORD_SIZE, HEX_DIGITS, display_mode_t (MODE_HEX=0, MODE_RAW=1, MODE_SCROLL=2) and SEG_BLANK (7'h7F, all segments off, active-low).
REQ-033 One sub-module tick_divider (parameter DIV, ports clk, rst_n, clr, tick) SHALL implement both prescalers.

Verification (bench NUM_DIGITS=6, BLINK_DIV=4, SCROLL_DIV=3)
REQ-034 Reset release, no commit, 20 cycles -> all hex_out = 7'h7F, commit_ack never high.
REQ-035 Write entries 0..5 = 8'h00..8'h05, commit, MODE_HEX -> commit_ack high 1 cycle after commit; hex_out[i] = HEX_DIGITS'(i) on 2nd edge after commit.
REQ-036 Write entry 2 = 8'h0A with commit in same cycle -> hex_out[2] = HEX_DIGITS'(4'hA) 2 edges later.
REQ-037 MODE_SCROLL with entries 0..5 -> digit 0 shows 0,1,2,3,4,5,0 every 3 cycles; switching to MODE_HEX restores digit 0 = 0 next edge.
REQ-038 blink_mask = 6'b000001, MODE_RAW, entry 0 = 8'h40 -> hex_out[0] alternates 7'h40 / 7'h7F every 4 cycles; other digits steady.
REQ-039 rst_n pulsed low for 1 cycle during scroll offset 3 -> hex_out all 7'h7F immediately, offset 0, blank until next commit.
